vx_barrier_unit: RTL
====================

# VX_barrier_unit

Per-core warp barrier tracker, downstream of the GPU control unit that emits barrier requests (valid, id, size_m1) alongside TMC/WSPAWN/SPLIT. It counts warp arrivals per barrier ID, holds arriving warps stalled, and releases every waiting warp together when the last expected warp arrives. Its stall and release masks feed the warp scheduler.

## Interface
- NUM_WARPS, 4: warps per core; power of two, ≥2.
- NUM_BARRIERS, 4: barrier IDs per core; power of two, ≥2.
- NW_BITS, $clog2(NUM_WARPS): warp index / size width.
- NB_BITS, $clog2(NUM_BARRIERS): barrier ID width.

- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- barrier_valid  in  1  arrival request this cycle; no backpressure, one per cycle max.
- barrier_id  in  NB_BITS  target barrier.
- barrier_size_m1  in  NW_BITS  expected warp count minus 1.
- barrier_wid  in  NW_BITS  arriving warp index.
- stalled_warps  out  NUM_WARPS  OR of all barrier wait masks (registered).
- release_valid  out  1  one-cycle pulse: a barrier completed.
- release_mask  out  NUM_WARPS  warps released by that completion, including the final arriver.
- barrier_busy  out  NUM_BARRIERS  bit b set while barrier b has ≥1 waiting warp.

## Operation
- Per-barrier state: count[b] (NW_BITS, arrivals so far) and wait_mask[b] (NUM_WARPS).
- Arrival on barrier b from warp w, when wait_mask[b][w] = 0:
  - If count[b] == barrier_size_m1, the barrier completes. Set release_mask = wait_mask[b] | (1<<w), pulse release_valid, clear count[b] and wait_mask[b]. Warp w is never marked stalled.
  - Otherwise, increment count[b] and set wait_mask[b][w].
- Duplicate arrival, where wait_mask[b][w] is already 1: ignored. No count change and no release. This is a protocol error; the bench flags it with an assertion.
- barrier_size_m1 == 0 completes immediately with release_mask = (1<<w).
- The completion check uses the size from the current request only. Earlier sizes are not stored.
- Count never exceeds size_m1. Completion happens at equality and the counter resets, so there is no wrap.
- Barriers are fully independent. A warp waiting on one barrier does not affect any other barrier.
- stalled_warps = OR over b of wait_mask[b]. It is derived from registers, not from the current-cycle input.
- barrier_busy[b] = |wait_mask[b].
- There is no FSM beyond the per-barrier states: IDLE (count 0, mask 0) and WAITING (mask ≠ 0).
  - IDLE→WAITING on a non-completing arrival.
  - WAITING→IDLE on a completing arrival.
  - IDLE→IDLE on an arrival with size_m1 = 0.

## Timing
- Reset values: all count 0, all wait_mask 0, release_valid 0, release_mask 0, stalled_warps 0, barrier_busy 0.
- An async assert clears state immediately, including mid-wait. Waiting warps are dropped and no release is issued.
- Arrival sampled at edge N gives:
  - release_valid/release_mask valid in cycle N+1, lasting one cycle;
  - stalled_warps/barrier_busy updated from N+1.
- On completion, waiting warps' stalled_warps bits clear in the same cycle (N+1) that release_valid asserts.
- release_mask reads 0 whenever release_valid is 0.
- Back-to-back arrivals on consecutive cycles, same or different barrier, are all accepted. The request at N+1 sees the state written at edge N.

## Test plan
- Reset: hold reset low for 3 cycles mid-stimulus, then release -> all outputs 0, barrier_busy = 0000.
- Four-warp barrier (NUM_WARPS = 4): id 1, size_m1 = 3; arrivals from wid 0, 2, 1 on consecutive cycles.
  - stalled_warps goes 0001, 0101, 0111.
  - wid 3 then arrives -> next cycle release_valid = 1, release_mask = 1111, stalled_warps = 0000, barrier_busy[1] = 0.
- size_m1 = 0 from wid 2 on id 0 -> release_valid = 1, release_mask = 0100, stalled_warps never sets bit 2.
- Independent barriers: wid 0 waits on id 0 (size 1) and wid 1 on id 2 (size 1); then wid 3 arrives on id 2 -> release_mask = 1010, stalled_warps = 0001, barrier_busy = 0001.
- Duplicate arrival: wid 1 arrives twice on id 3 (size 2) -> count stays 1, no release, stalled_warps = 0010, assertion fires.
- Reset mid-wait: three warps waiting on id 1 (size 3), then assert reset -> stalled_warps = 0000 immediately, and no release_valid after reset is released.

Source files
------------

// File: rtl/vx_barrier_unit.sv
`default_nettype none
// ============================================================================
//  Module      : vx_barrier_unit
//  Description : Per-core warp barrier tracker. Counts warp arrivals for each
//                barrier ID and holds the arriving warps stalled. When the
//                last expected warp arrives, it releases every waiting warp at
//                once.
//  Ports       : clk              - clock, rising edge
//                reset            - asynchronous, active-low reset
//                barrier_valid    - arrival request this cycle
//                barrier_id       - target barrier
//                barrier_size_m1  - expected warp count minus one
//                barrier_wid      - arriving warp index
//                stalled_warps    - OR of all barrier wait masks
//                release_valid    - one-cycle completion pulse
//                release_mask     - warps released by that completion
//                barrier_busy     - per-barrier "has waiting warps" flag
//  Revision    : 1.0 - initial release
// ============================================================================
module vx_barrier_unit #(
    parameter int NUM_WARPS    = 4,
    parameter int NUM_BARRIERS = 4,
    parameter int NW_BITS      = $clog2(NUM_WARPS),
    parameter int NB_BITS      = $clog2(NUM_BARRIERS)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    barrier_valid,
    input  logic [NB_BITS-1:0]      barrier_id,
    input  logic [NW_BITS-1:0]      barrier_size_m1,
    input  logic [NW_BITS-1:0]      barrier_wid,
    output logic [NUM_WARPS-1:0]    stalled_warps,
    output logic                    release_valid,
    output logic [NUM_WARPS-1:0]    release_mask,
    output logic [NUM_BARRIERS-1:0] barrier_busy
);

    // Per-barrier state: arrivals so far and the set of warps held at it.
    logic [NW_BITS-1:0]   r_count     [NUM_BARRIERS];
    logic [NUM_WARPS-1:0] r_wait_mask [NUM_BARRIERS];
    logic                 r_release_valid;
    logic [NUM_WARPS-1:0] r_release_mask;

    logic [NUM_WARPS-1:0] w_warp_onehot;
    logic [NUM_WARPS-1:0] w_cur_mask;
    logic [NW_BITS-1:0]   w_cur_count;
    logic                 w_dup;
    logic                 w_complete;
    logic [NUM_WARPS-1:0] w_stalled;

    assign w_warp_onehot = NUM_WARPS'(1) << barrier_wid;
    assign w_cur_mask    = r_wait_mask[barrier_id];
    assign w_cur_count   = r_count[barrier_id];

    // A warp already waiting on this barrier is re-arriving: a protocol
    // error that must neither count nor trigger a release.
    assign w_dup      = |(w_cur_mask & w_warp_onehot);

    // Completion uses the size carried by this request only.
    assign w_complete = (w_cur_count == barrier_size_m1);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int b = 0; b < NUM_BARRIERS; b++) begin
                r_count[b]     <= '0;
                r_wait_mask[b] <= '0;
            end
            r_release_valid <= 1'b0;
            r_release_mask  <= '0;
        end else begin
            // Release outputs are single-cycle pulses; mask reads 0 otherwise.
            r_release_valid <= 1'b0;
            r_release_mask  <= '0;
            if (barrier_valid && !w_dup) begin
                if (w_complete) begin
                    // The final arriver is released directly and never stalls.
                    r_release_valid         <= 1'b1;
                    r_release_mask          <= w_cur_mask | w_warp_onehot;
                    r_count[barrier_id]     <= '0;
                    r_wait_mask[barrier_id] <= '0;
                end else begin
                    r_count[barrier_id]     <= w_cur_count + NW_BITS'(1);
                    r_wait_mask[barrier_id] <= w_cur_mask | w_warp_onehot;
                end
            end
        end
    end

    // Stall view is built from the stored masks only, so a completing
    // arrival clears the waiters' bits in the same cycle the pulse appears.
    always_comb begin
        w_stalled = '0;
        for (int b = 0; b < NUM_BARRIERS; b++) begin
            w_stalled = w_stalled | r_wait_mask[b];
        end
    end

    generate
        for (genvar g = 0; g < NUM_BARRIERS; g++) begin : g_busy
            assign barrier_busy[g] = |r_wait_mask[g];
        end
    endgenerate

    assign stalled_warps = w_stalled;
    assign release_valid = r_release_valid;
    assign release_mask  = r_release_mask;

endmodule
`default_nettype wire
